// File: rtl/mips_pkg.sv
// Shared MIPS constants and fetch-stage types for the instruction fetch unit.
// Opcodes and functs are decoded by the control unit. The fetch stage only needs the state type and the reset address.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } fetchState_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack bus. The fetch unit is the master.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the fetch unit.
// The selection priority is Jr, then Jump, then a taken branch, then the sequential PC.
module next_pc_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       instrIndex,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              Jump,
  input  logic              Jr,
  input  logic [ADDR_W-1:0] jrTarget,
  output logic [ADDR_W-1:0] pcPlus4,
  output logic [ADDR_W-1:0] nextPc,
  output logic              misaligned
);

  logic [ADDR_W-1:0] jumpTarget;
  logic [ADDR_W-1:0] branchTarget;

  // All adds wrap modulo 2^ADDR_W, so pc=FFFF_FFFC rolls over to 0.
  assign pcPlus4      = pc + ADDR_W'(4);
  assign jumpTarget   = {pcPlus4[ADDR_W-1:28], instrIndex, 2'b00};
  assign branchTarget = pcPlus4 + {{(ADDR_W-18){instrIndex[15]}}, instrIndex[15:0], 2'b00};

  always_comb begin
    nextPc = pcPlus4;
    if (Jr)                nextPc = jrTarget;
    else if (Jump)         nextPc = jumpTarget;
    else if (Branch && Zero) nextPc = branchTarget;
  end

  assign misaligned = (nextPc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage. It owns the PC, fetches over the imem req/ack bus and holds the current instruction for the control unit.
// HALT is entered on a misaligned redirect and is left only by reset.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                Branch,
  input  logic                Zero,
  input  logic                Jump,
  input  logic                Jr,
  input  logic [ADDR_W-1:0]   jr_target,
  output logic [DATA_W-1:0]   instr,
  output logic [5:0]          OpCode,
  output logic [5:0]          Funct,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus4,
  output logic                fault
);

  fetchState_t       stateQ, stateNext;
  logic [ADDR_W-1:0] pcNext;
  logic [DATA_W-1:0] instrNext;
  logic [ADDR_W-1:0] nextPc;
  logic              misaligned;

  next_pc_calc #(.ADDR_W(ADDR_W)) uNextPc (
    .pc         (pc),
    .instrIndex (instr[25:0]),
    .Branch     (Branch),
    .Zero       (Zero),
    .Jump       (Jump),
    .Jr         (Jr),
    .jrTarget   (jr_target),
    .pcPlus4    (pc_plus4),
    .nextPc     (nextPc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
      pc     <= RESET_PC;
      instr  <= '0;
    end else begin
      stateQ <= stateNext;
      pc     <= pcNext;
      instr  <= instrNext;
    end
  end

  // Acks are only honoured in REQ. Redirects are only honoured when EXEC retires.
  always_comb begin
    stateNext = stateQ;
    pcNext    = pc;
    instrNext = instr;
    case (stateQ)
      IDLE: stateNext = REQ;
      REQ: begin
        if (imem.imem_ack) begin
          instrNext = imem.imem_rdata;
          stateNext = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (misaligned) begin
            stateNext = HALT;
          end else begin
            pcNext    = nextPc;
            stateNext = REQ;
          end
        end
      end
      HALT:    stateNext = HALT;
      default: stateNext = IDLE;
    endcase
  end

  assign imem.imem_req  = (stateQ == REQ);
  assign imem.imem_addr = pc;
  assign instr_valid    = (stateQ == EXEC);
  assign fault          = (stateQ == HALT);
  assign OpCode         = instr[31:26];
  assign Funct          = instr[5:0];

endmodule
